// File: rtl/calc_alu_seq.sv
// calc_alu_seq: digit-serial signed BCD floating add/subtract sequencer.
// Operands are aligned, ordered by magnitude and summed one BCD digit per
// cycle through a single shared digit adder, then normalized.

package calc_pkg;
  localparam int NumDigits = 8;
  localparam int ExpW      = 4;

  typedef logic [NumDigits-1:0][3:0] sig_t;

  typedef struct packed {
    logic            sign;
    sig_t            sig;
    logic [ExpW-1:0] exp;
    logic            error;
  } num_t;
endpackage

module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int MaxExp = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  logic op_i,
  input  num_t left_i,
  input  num_t right_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output num_t result_o,
  output logic busy_o
);

  localparam int N = NumDigits;
  localparam logic [ExpW-1:0] MAX_EXP_C = ExpW'(MaxExp);
  localparam logic [ExpW-1:0] N_C       = ExpW'(N);
  localparam logic [ExpW-1:0] LAST_C    = ExpW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN  = 3'd1,
    S_ORDER  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_NORM_L = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // One BCD digit add: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add_digit(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (s > 5'd9) begin
      bcd_add_digit = {1'b1, s[3:0] + 4'd6};
    end else begin
      bcd_add_digit = {1'b0, s[3:0]};
    end
  endfunction

  // One BCD digit subtract a-b-bin: returns {borrow_out, digit}.
  function automatic logic [4:0] bcd_sub_digit(input logic [3:0] a, input logic [3:0] b,
                                               input logic bin);
    logic [4:0] s;
    s = {1'b0, a} - {1'b0, b} - {4'd0, bin};
    if (s[4]) begin
      bcd_sub_digit = {1'b1, s[3:0] + 4'd10};
    end else begin
      bcd_sub_digit = {1'b0, s[3:0]};
    end
  endfunction

  // Final result packing: a zero magnitude without error is always positive.
  function automatic num_t pack_result(input logic sign, input sig_t sig,
                                       input logic [ExpW-1:0] exp, input logic err);
    num_t r;
    r.sign  = ((sig == '0) && !err) ? 1'b0 : sign;
    r.sig   = sig;
    r.exp   = exp;
    r.error = err;
    return r;
  endfunction

  state_t          state_r;
  logic            ready_r;
  sig_t            a_sig_r;
  sig_t            b_sig_r;
  logic            a_sign_r;
  logic            b_sign_r;
  logic [ExpW-1:0] exp_r;
  logic            shift_a_r;
  logic [ExpW-1:0] cnt_r;
  logic            sub_r;
  logic            carry_r;
  logic            ovf_r;
  logic            in_err_r;
  sig_t            res_sig_r;
  logic            res_sign_r;
  logic [ExpW-1:0] res_exp_r;
  logic            res_err_r;

  logic            shift_a_s;
  logic [ExpW-1:0] diff_s;
  logic [ExpW-1:0] d_s;
  logic [ExpW-1:0] max_exp_s;
  logic            swap_s;
  logic [4:0]      dig_s;
  sig_t            norm_sig_s;
  logic [ExpW-1:0] norm_exp_s;
  logic            norm_err_s;
  logic            norm_l_go_s;

  assign in_ready_o = ready_r & ~rst_i;

  // Alignment distance and common exponent of the incoming operands.
  always_comb begin
    shift_a_s = 1'b0;
    diff_s    = '0;
    max_exp_s = '0;
    d_s       = '0;
    if (left_i.exp < right_i.exp) begin
      shift_a_s = 1'b1;
      diff_s    = right_i.exp - left_i.exp;
      max_exp_s = right_i.exp;
    end else begin
      shift_a_s = 1'b0;
      diff_s    = left_i.exp - right_i.exp;
      max_exp_s = left_i.exp;
    end
    if (diff_s > N_C) begin
      d_s = N_C;
    end else begin
      d_s = diff_s;
    end
  end

  // Magnitude order and the shared serial digit adder/subtractor.
  always_comb begin
    swap_s = (b_sig_r > a_sig_r);
    if (sub_r) begin
      dig_s = bcd_sub_digit(a_sig_r[0], b_sig_r[0], carry_r);
    end else begin
      dig_s = bcd_add_digit(a_sig_r[0], b_sig_r[0], carry_r);
    end
  end

  // Overflow-digit normalization and error/exponent resolution.
  always_comb begin
    norm_sig_s = res_sig_r;
    norm_exp_s = exp_r;
    norm_err_s = in_err_r;
    if (ovf_r) begin
      norm_sig_s = sig_t'({4'd1, res_sig_r[N-1:1]});
      if (exp_r == MAX_EXP_C) begin
        norm_err_s = 1'b1;
      end else begin
        norm_exp_s = exp_r + {{(ExpW-1){1'b0}}, 1'b1};
      end
    end else begin
      norm_sig_s = res_sig_r;
    end
    if (norm_err_s) begin
      norm_exp_s = '0;
    end else begin
      norm_exp_s = norm_exp_s;
    end
  end

  // Left normalization continues while there is exponent to spend and a leading zero.
  always_comb begin
    if (!res_err_r && (res_exp_r != '0) && (res_sig_r[N-1] == 4'd0)) begin
      norm_l_go_s = 1'b1;
    end else begin
      norm_l_go_s = 1'b0;
    end
  end

  // Sequencer FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= S_IDLE;
      ready_r     <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      result_o    <= '0;
      a_sig_r     <= '0;
      b_sig_r     <= '0;
      a_sign_r    <= 1'b0;
      b_sign_r    <= 1'b0;
      exp_r       <= '0;
      shift_a_r   <= 1'b0;
      cnt_r       <= '0;
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      in_err_r    <= 1'b0;
      res_sig_r   <= '0;
      res_sign_r  <= 1'b0;
      res_exp_r   <= '0;
      res_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid_i && ready_r) begin
            a_sig_r   <= left_i.sig;
            b_sig_r   <= right_i.sig;
            a_sign_r  <= left_i.sign;
            b_sign_r  <= right_i.sign ^ op_i;
            exp_r     <= max_exp_s;
            shift_a_r <= shift_a_s;
            cnt_r     <= d_s;
            in_err_r  <= left_i.error | right_i.error;
            ready_r   <= 1'b0;
            busy_o    <= 1'b1;
            state_r   <= (d_s != '0) ? S_ALIGN : S_ORDER;
          end
        end
        S_ALIGN: begin
          // Truncating right shift of the smaller-exponent operand.
          if (shift_a_r) begin
            a_sig_r <= sig_t'({4'd0, a_sig_r[N-1:1]});
          end else begin
            b_sig_r <= sig_t'({4'd0, b_sig_r[N-1:1]});
          end
          cnt_r <= cnt_r - {{(ExpW-1){1'b0}}, 1'b1};
          if (cnt_r == {{(ExpW-1){1'b0}}, 1'b1}) begin
            state_r <= S_ORDER;
          end
        end
        S_ORDER: begin
          if (swap_s) begin
            a_sig_r    <= b_sig_r;
            b_sig_r    <= a_sig_r;
            res_sign_r <= b_sign_r;
          end else begin
            res_sign_r <= a_sign_r;
          end
          sub_r   <= a_sign_r ^ b_sign_r;
          carry_r <= 1'b0;
          cnt_r   <= '0;
          state_r <= S_ADD;
        end
        S_ADD: begin
          res_sig_r <= sig_t'({dig_s[3:0], res_sig_r[N-1:1]});
          a_sig_r   <= sig_t'({4'd0, a_sig_r[N-1:1]});
          b_sig_r   <= sig_t'({4'd0, b_sig_r[N-1:1]});
          carry_r   <= dig_s[4];
          cnt_r     <= cnt_r + {{(ExpW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_C) begin
            ovf_r   <= ~sub_r & dig_s[4];
            state_r <= S_NORM;
          end
        end
        S_NORM: begin
          res_sig_r <= norm_sig_s;
          res_exp_r <= norm_exp_s;
          res_err_r <= norm_err_s;
          state_r   <= S_NORM_L;
        end
        S_NORM_L: begin
          if (norm_l_go_s) begin
            res_sig_r <= sig_t'({res_sig_r[N-2:0], 4'd0});
            res_exp_r <= res_exp_r - {{(ExpW-1){1'b0}}, 1'b1};
          end else begin
            result_o    <= pack_result(res_sign_r, res_sig_r, res_exp_r, res_err_r);
            out_valid_o <= 1'b1;
            state_r     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            ready_r     <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          ready_r     <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
